// File: rtl/lsq_dcache_arbiter_if.sv
// Bundle of the LQ/SQ request, D-cache request/response and LQ response signals.
// slave = arbiter side, master = LSQ/cache environment side.
interface lsq_dcache_arbiter_if #(
    parameter int ADDR_W   = 32,
    parameter int SIZE_W   = 2,
    parameter int BLOCK_W  = 64,
    parameter int ROB_W    = 5,
    parameter int SQ_W     = 8,
    parameter int OUT_W    = 3,
    parameter int STARVE_W = 4
);
    logic               ld_req_valid_i;
    logic [ADDR_W-1:0]  ld_req_addr_i;
    logic [SIZE_W-1:0]  ld_req_size_i;
    logic [ROB_W-1:0]   ld_req_rob_idx_i;
    logic               ld_req_accept_o;
    logic               st_req_valid_i;
    logic [ADDR_W-1:0]  st_req_addr_i;
    logic [SIZE_W-1:0]  st_req_size_i;
    logic [BLOCK_W-1:0] st_req_data_i;
    logic [ROB_W-1:0]   st_req_rob_idx_i;
    logic               st_req_accept_o;
    logic [SQ_W-1:0]    sq_count_i;
    logic [ADDR_W-1:0]  dc_addr_o;
    logic [1:0]         dc_command_o;
    logic [SIZE_W-1:0]  dc_size_o;
    logic [BLOCK_W-1:0] dc_store_data_o;
    logic [ROB_W-1:0]   dc_rob_idx_o;
    logic               dc_req_accept_i;
    logic               dc_valid_out_i;
    logic [BLOCK_W-1:0] dc_data_out_i;
    logic [ROB_W-1:0]   dc_data_rob_idx_i;
    logic               ld_resp_valid_o;
    logic [BLOCK_W-1:0] ld_resp_data_o;
    logic [ROB_W-1:0]   ld_resp_rob_idx_o;
    logic [OUT_W-1:0]   outstanding_o;
    logic [1:0]         dbg_state;
    logic [STARVE_W-1:0] dbg_starve_cnt;
    logic               dbg_drain_mode;

    // Handshake: a request transfers on a cycle where the cache sees a non-NONE
    // command and dc_req_accept_i is high; the requester holds its fields until then.
    modport slave (
        input  ld_req_valid_i, ld_req_addr_i, ld_req_size_i, ld_req_rob_idx_i,
        input  st_req_valid_i, st_req_addr_i, st_req_size_i, st_req_data_i, st_req_rob_idx_i,
        input  sq_count_i, dc_req_accept_i, dc_valid_out_i, dc_data_out_i, dc_data_rob_idx_i,
        output ld_req_accept_o, st_req_accept_o,
        output dc_addr_o, dc_command_o, dc_size_o, dc_store_data_o, dc_rob_idx_o,
        output ld_resp_valid_o, ld_resp_data_o, ld_resp_rob_idx_o, outstanding_o,
        output dbg_state, dbg_starve_cnt, dbg_drain_mode
    );

    modport master (
        output ld_req_valid_i, ld_req_addr_i, ld_req_size_i, ld_req_rob_idx_i,
        output st_req_valid_i, st_req_addr_i, st_req_size_i, st_req_data_i, st_req_rob_idx_i,
        output sq_count_i, dc_req_accept_i, dc_valid_out_i, dc_data_out_i, dc_data_rob_idx_i,
        input  ld_req_accept_o, st_req_accept_o,
        input  dc_addr_o, dc_command_o, dc_size_o, dc_store_data_o, dc_rob_idx_o,
        input  ld_resp_valid_o, ld_resp_data_o, ld_resp_rob_idx_o, outstanding_o,
        input  dbg_state, dbg_starve_cnt, dbg_drain_mode
    );
endinterface

// File: rtl/lsq_dcache_arbiter.sv
// Shares one D-cache request port between LQ and SQ with grant lock, drain mode and
// store starvation guard. Optional perf counters under `LSQ_ARB_PERF_EN.
module lsq_dcache_arbiter #(
    parameter int STARVE_LIMIT    = 8,
    parameter int DRAIN_HI        = 6,
    parameter int DRAIN_LO        = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SQ_SIZE         = 128,
    parameter int ADDR_W          = 32,
    parameter int SIZE_W          = 2,
    parameter int BLOCK_W         = 64,
    parameter int ROB_W           = 5
) (
    input  logic clock,
    input  logic reset,
    lsq_dcache_arbiter_if.slave bus
`ifdef LSQ_ARB_PERF_EN
    ,
    output logic [31:0] perf_ld_grants_o,
    output logic [31:0] perf_st_grants_o,
    output logic [31:0] perf_forced_o,
    output logic [31:0] perf_conflict_o
`endif
);
    localparam int SQ_W     = $clog2(SQ_SIZE + 1);
    localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;

    localparam logic [SQ_W-1:0]     DRAIN_HI_C  = SQ_W'(DRAIN_HI);
    localparam logic [SQ_W-1:0]     DRAIN_LO_C  = SQ_W'(DRAIN_LO);
    localparam logic [OUT_W-1:0]    MAX_OUT_C   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [STARVE_W-1:0] STARVE_LIM_C = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {ARB = 2'd0, LOCK_LD = 2'd1, LOCK_ST = 2'd2} state_e;

    state_e              state, state_next;
    logic [STARVE_W-1:0] starve_cnt;
    logic                drain_mode;
    logic [OUT_W-1:0]    outstanding;
    logic                ld_elig, st_elig, forced;
    logic                grant_ld, grant_st;
    logic                ld_accept, st_accept;

    assign ld_elig = bus.ld_req_valid_i && (outstanding < MAX_OUT_C);
    assign st_elig = bus.st_req_valid_i;

    always_ff @(posedge clock) begin
        if (reset) state <= ARB;
        else       state <= state_next;
    end

    // Locked states ignore priority and only follow the locked requester's valid.
    always_comb begin
        state_next = state;
        grant_ld   = 1'b0;
        grant_st   = 1'b0;
        forced     = 1'b0;
        case (state)
            ARB: begin
                forced = (starve_cnt == STARVE_LIM_C) && st_elig;
                if (forced) begin
                    grant_st = 1'b1;
                end else if (drain_mode) begin
                    grant_st = st_elig;
                    grant_ld = !st_elig && ld_elig;
                end else begin
                    grant_ld = ld_elig;
                    grant_st = !ld_elig && st_elig;
                end
            end
            LOCK_LD: grant_ld = bus.ld_req_valid_i;
            LOCK_ST: grant_st = bus.st_req_valid_i;
            default: ;
        endcase
        if (grant_ld && !bus.dc_req_accept_i)      state_next = LOCK_LD;
        else if (grant_st && !bus.dc_req_accept_i) state_next = LOCK_ST;
        else                                       state_next = ARB;
    end

    assign ld_accept = grant_ld && bus.dc_req_accept_i;
    assign st_accept = grant_st && bus.dc_req_accept_i;

    always_comb begin
        bus.dc_command_o    = MEM_NONE;
        bus.dc_addr_o       = '0;
        bus.dc_size_o       = '0;
        bus.dc_store_data_o = '0;
        bus.dc_rob_idx_o    = '0;
        if (grant_ld) begin
            bus.dc_command_o = MEM_LOAD;
            bus.dc_addr_o    = bus.ld_req_addr_i;
            bus.dc_size_o    = bus.ld_req_size_i;
            bus.dc_rob_idx_o = bus.ld_req_rob_idx_i;
        end else if (grant_st) begin
            bus.dc_command_o    = MEM_STORE;
            bus.dc_addr_o       = bus.st_req_addr_i;
            bus.dc_size_o       = bus.st_req_size_i;
            bus.dc_store_data_o = bus.st_req_data_i;
            bus.dc_rob_idx_o    = bus.st_req_rob_idx_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt  <= '0;
            drain_mode  <= 1'b0;
            outstanding <= '0;
        end else begin
            if (bus.st_req_valid_i && !st_accept) begin
                if (starve_cnt != STARVE_LIM_C) starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
            if (bus.sq_count_i >= DRAIN_HI_C)      drain_mode <= 1'b1;
            else if (bus.sq_count_i <= DRAIN_LO_C) drain_mode <= 1'b0;
            // Responses for loads issued before reset must not underflow the count.
            if (ld_accept && !bus.dc_valid_out_i)
                outstanding <= outstanding + 1'b1;
            else if (!ld_accept && bus.dc_valid_out_i && outstanding != '0)
                outstanding <= outstanding - 1'b1;
        end
    end

`ifdef LSQ_ARB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ld_grants_o <= '0;
            perf_st_grants_o <= '0;
            perf_forced_o    <= '0;
            perf_conflict_o  <= '0;
        end else begin
            if (ld_accept) perf_ld_grants_o <= perf_ld_grants_o + 32'd1;
            if (st_accept) perf_st_grants_o <= perf_st_grants_o + 32'd1;
            if (forced)    perf_forced_o    <= perf_forced_o + 32'd1;
            if (bus.ld_req_valid_i && bus.st_req_valid_i)
                perf_conflict_o <= perf_conflict_o + 32'd1;
        end
    end
`endif

    assign bus.ld_req_accept_o   = ld_accept;
    assign bus.st_req_accept_o   = st_accept;
    assign bus.ld_resp_valid_o   = bus.dc_valid_out_i;
    assign bus.ld_resp_data_o    = bus.dc_data_out_i;
    assign bus.ld_resp_rob_idx_o = bus.dc_data_rob_idx_i;
    assign bus.outstanding_o     = outstanding;
    assign bus.dbg_state         = state;
    assign bus.dbg_starve_cnt    = starve_cnt;
    assign bus.dbg_drain_mode    = drain_mode;
endmodule
